// File: rtl/cest_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cest_pkg
// Brief   : Shared constants, state encoding and clog2 helper for the
//           channel-estimate averaging controller.
// Revision: 1.0 - initial release
// ============================================================================
package cest_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int N        = 64;
  localparam int NSYM     = 4;
  localparam int DW       = 12;
  localparam int AW       = clog2(N);
  localparam int SW       = (clog2(NSYM) > 0) ? clog2(NSYM) : 1;
  localparam int RD_LAT   = 1;
  localparam int PIPE_LAT = 3;
  localparam int DLY      = RD_LAT + PIPE_LAT;
  localparam int FW       = clog2(DLY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cest_avg_ctrl_vld_dly_line.sv
`default_nettype none
// ============================================================================
// Module  : vld_dly_line
// Brief   : Async-reset shift register with synchronous clear, used to align
//           read strobes with the adder-tree output.
// Revision: 1.0 - initial release
// ============================================================================
module vld_dly_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cest_avg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cest_avg_ctrl
// Brief   : Sequencer that frames NSYM x N channel estimates into per-symbol
//           banks, then drains all banks in lockstep and flags averaged output.
// Revision: 1.0 - initial release
// ============================================================================
module cest_avg_ctrl
  import cest_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [DW-1:0]   i_din_re,
  input  logic [DW-1:0]   i_din_im,
  input  logic            i_din_vld,
  input  logic            i_rd_stall,
  output logic [NSYM-1:0] o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic [DW-1:0]   o_wr_re,
  output logic [DW-1:0]   o_wr_im,
  output logic            o_rd_en,
  output logic [AW-1:0]   o_rd_addr,
  output logic            o_avg_vld,
  output logic            o_avg_last,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err_ovf,
  output logic            o_err_abort
);

  localparam logic [AW-1:0] c_SC_LAST  = AW'(N - 1);
  localparam logic [SW-1:0] c_SYM_LAST = SW'(NSYM - 1);
  localparam logic [FW-1:0] c_FL_DONE  = FW'(DLY - 1);
  localparam logic [FW-1:0] c_FL_END   = FW'(DLY);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_sc_cnt;
  logic [SW-1:0]   r_sym_cnt;
  logic [AW-1:0]   r_rd_cnt;
  logic [FW-1:0]   r_fl_cnt;

  logic [NSYM-1:0] r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_re;
  logic [DW-1:0]   r_wr_im;
  logic            r_rd_en;
  logic [AW-1:0]   r_rd_addr;
  logic            r_busy;
  logic            r_done;
  logic            r_err_ovf;
  logic            r_err_abort;

  logic            w_abort;
  logic            w_wr_acc;
  logic            w_rd_iss;
  logic            w_fill_last;
  logic            w_rd_last;
  logic            w_fl_end;

  logic [NSYM-1:0] w_wr_en_nxt;
  logic            w_done_nxt;
  logic            w_err_ovf_nxt;
  logic [1:0]      w_dly_in;
  logic [1:0]      w_dly_out;

  // A start always wins: it re-arms the packet and suppresses any write or read that cycle.
  assign w_abort     = i_start && (r_state != IDLE);
  assign w_wr_acc    = (r_state == FILL) && i_din_vld && !i_start;
  assign w_rd_iss    = (r_state == DRAIN) && !i_rd_stall && !i_start;
  assign w_fill_last = w_wr_acc && (r_sc_cnt == c_SC_LAST) && (r_sym_cnt == c_SYM_LAST);
  assign w_rd_last   = w_rd_iss && (r_rd_cnt == c_SC_LAST);
  assign w_fl_end    = (r_state == FLUSH) && (r_fl_cnt == c_FL_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_fill_last) w_state_nxt = DRAIN;
        DRAIN:   if (w_rd_last)   w_state_nxt = FLUSH;
        FLUSH:   if (w_fl_end)    w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_wr_en_nxt   = w_wr_acc ? (NSYM'(1) << r_sym_cnt) : '0;
    w_done_nxt    = (r_state == FLUSH) && !i_start && (r_fl_cnt == c_FL_DONE);
    w_err_ovf_nxt = i_din_vld && ((r_state != FILL) || i_start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc_cnt  <= '0;
      r_sym_cnt <= '0;
      r_rd_cnt  <= '0;
      r_fl_cnt  <= '0;
    end else if (i_start) begin
      r_sc_cnt  <= '0;
      r_sym_cnt <= '0;
      r_rd_cnt  <= '0;
      r_fl_cnt  <= '0;
    end else begin
      if (w_wr_acc) begin
        if (r_sc_cnt == c_SC_LAST) begin
          r_sc_cnt  <= '0;
          r_sym_cnt <= (r_sym_cnt == c_SYM_LAST) ? '0 : r_sym_cnt + SW'(1);
        end else begin
          r_sc_cnt <= r_sc_cnt + AW'(1);
        end
      end
      if (w_rd_iss) begin
        r_rd_cnt <= (r_rd_cnt == c_SC_LAST) ? '0 : r_rd_cnt + AW'(1);
      end
      r_fl_cnt <= (r_state == FLUSH) ? r_fl_cnt + FW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_wr_re     <= '0;
      r_wr_im     <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_iss;
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= w_done_nxt;
      r_err_ovf   <= w_err_ovf_nxt;
      r_err_abort <= w_abort;
      if (w_wr_acc) begin
        r_wr_addr <= r_sc_cnt;
        r_wr_re   <= i_din_re;
        r_wr_im   <= i_din_im;
      end
      if (w_rd_iss) begin
        r_rd_addr <= r_rd_cnt;
      end else if (i_start) begin
        r_rd_addr <= '0;
      end
    end
  end

  assign w_dly_in = {r_rd_en, r_rd_en && (r_rd_addr == c_SC_LAST)};

  vld_dly_line #(
    .WIDTH (2),
    .DEPTH (DLY)
  ) u_vld_dly (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_abort),
    .i_din  (w_dly_in),
    .o_dout (w_dly_out)
  );

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_re     = r_wr_re;
  assign o_wr_im     = r_wr_im;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_avg_vld   = w_dly_out[1];
  assign o_avg_last  = w_dly_out[0];
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_abort = r_err_abort;

endmodule
`default_nettype wire

// File: tb/tb_cest_avg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cest_avg_ctrl
// Brief   : Scoreboard bench for cest_avg_ctrl: expected writes and reads are
//           queued by the stimulus and popped by an independent monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cest_avg_ctrl;

  typedef struct packed {
    logic [3:0]  en;
    logic [5:0]  addr;
    logic [11:0] re;
    logic [11:0] im;
  } wr_t;

  typedef struct packed {
    int   t;
    logic last;
  } avg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [11:0] i_din_re;
  logic [11:0] i_din_im;
  logic        i_din_vld;
  logic        i_rd_stall;
  logic [3:0]  o_wr_en;
  logic [5:0]  o_wr_addr;
  logic [11:0] o_wr_re;
  logic [11:0] o_wr_im;
  logic        o_rd_en;
  logic [5:0]  o_rd_addr;
  logic        o_avg_vld;
  logic        o_avg_last;
  logic        o_busy;
  logic        o_done;
  logic        o_err_ovf;
  logic        o_err_abort;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   obs_ovf = 0;
  int   exp_ovf = 0;
  int   obs_abort = 0;
  int   exp_abort = 0;
  logic busy_chk = 1'b0;

  wr_t  wr_q[$];
  int   rd_q[$];
  avg_t avg_q[$];

  wire [46:0] all_out = {o_wr_en, o_wr_addr, o_wr_re, o_wr_im, o_rd_en, o_rd_addr,
                         o_avg_vld, o_avg_last, o_busy, o_done, o_err_ovf, o_err_abort};

  cest_avg_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_din_re    (i_din_re),
    .i_din_im    (i_din_im),
    .i_din_vld   (i_din_vld),
    .i_rd_stall  (i_rd_stall),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_re     (o_wr_re),
    .o_wr_im     (o_wr_im),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .o_avg_vld   (o_avg_vld),
    .o_avg_last  (o_avg_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err_ovf   (o_err_ovf),
    .o_err_abort (o_err_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, read or average
  always @(negedge clk) begin
    wr_t  we;
    avg_t ae;
    int   ra;
    if (rst) begin
      wr_q.delete();
      rd_q.delete();
      avg_q.delete();
      busy_chk = 1'b0;
    end else begin
      if (busy_chk) begin
        check("busy_after_done", 64'(o_busy), 64'd0);
        busy_chk = 1'b0;
      end
      if (o_err_ovf)   obs_ovf++;
      if (o_err_abort) obs_abort++;
      if (o_wr_en != 4'd0) begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'(o_wr_en), 64'd0);
        else begin
          we = wr_q.pop_front();
          check("wr", 64'({o_wr_en, o_wr_addr, o_wr_re, o_wr_im}), 64'(we));
        end
      end
      if (o_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'(o_rd_en), 64'd0);
        else begin
          ra = rd_q.pop_front();
          check("rd_addr", 64'(o_rd_addr), 64'(ra));
          avg_q.push_back('{t: cyc + 4, last: (ra == 63)});
        end
      end
      if (avg_q.size() > 0 && avg_q[0].t < cyc) begin
        ae = avg_q.pop_front();
        check("avg_missing", 64'(cyc), 64'(ae.t));
      end
      if (o_avg_vld) begin
        if (avg_q.size() == 0) check("avg_unexpected", 64'(o_avg_vld), 64'd0);
        else begin
          ae = avg_q.pop_front();
          check("avg_time", 64'(cyc), 64'(ae.t));
          check("avg_last", 64'(o_avg_last), 64'(ae.last));
          if (ae.last) begin
            check("done_with_last", 64'(o_done), 64'd1);
            done_cnt++;
            busy_chk = 1'b1;
          end else if (o_done) begin
            check("done_early", 64'(o_done), 64'd0);
          end
        end
      end else if (o_done) begin
        check("done_spurious", 64'(o_done), 64'd0);
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic push_reads();
    for (int a = 0; a < 64; a++) rd_q.push_back(a);
  endtask

  task automatic send(input int count, input bit gap);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      i_din_vld = 1'b1;
      i_din_re  = 12'(k);
      i_din_im  = 12'(4095 - 3 * k);
      wr_q.push_back('{en: 4'(1 << (k / 64)), addr: 6'(k % 64),
                       re: 12'(k), im: 12'(4095 - 3 * k)});
      if (gap) begin
        @(negedge clk) i_din_vld = 1'b0;
      end
    end
    @(negedge clk) i_din_vld = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) timeout("wait_done");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rd(input int addr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_rd_en && o_rd_addr == 6'(addr)) && n < 3000);
    if (n >= 3000) timeout("wait_rd");
  endtask

  initial begin
    rst        = 1'b1;
    i_start    = 1'b0;
    i_din_re   = '0;
    i_din_im   = '0;
    i_din_vld  = 1'b0;
    i_rd_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(all_out), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Basic back-to-back packet
    start_pulse();
    check("busy_in_fill", 64'(o_busy), 64'd1);
    push_reads();
    send(256, 1'b0);
    wait_done(1);

    // Gapped input, 3-cycle stall at rd_addr 10, stray sample during DRAIN
    start_pulse();
    push_reads();
    send(256, 1'b1);
    wait_rd(10);
    i_rd_stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_rd_en", 64'(o_rd_en), 64'd0);
      check("stall_rd_addr", 64'(o_rd_addr), 64'd10);
    end
    i_rd_stall = 1'b0;
    wait_rd(40);
    i_din_vld = 1'b1;
    exp_ovf++;
    @(negedge clk);
    i_din_vld = 1'b0;
    check("ovf_pulse", 64'(o_err_ovf), 64'd1);
    @(negedge clk);
    check("ovf_one_cycle", 64'(o_err_ovf), 64'd0);
    wait_done(2);
    check("ovf_count", 64'(obs_ovf), 64'(exp_ovf));

    // Abort after 100 samples, with a coincident sample that must be dropped
    start_pulse();
    send(100, 1'b0);
    i_start   = 1'b1;
    i_din_vld = 1'b1;
    exp_ovf++;
    exp_abort++;
    @(negedge clk);
    i_start   = 1'b0;
    i_din_vld = 1'b0;
    check("abort_pulse", 64'(o_err_abort), 64'd1);
    check("abort_no_write", 64'(o_wr_en), 64'd0);
    push_reads();
    send(256, 1'b0);
    wait_done(3);
    check("abort_count", 64'(obs_abort), 64'(exp_abort));

    // Reset asserted mid-DRAIN
    start_pulse();
    push_reads();
    send(256, 1'b0);
    wait_rd(30);
    #1 rst = 1'b1;
    #1 check("rst_mid_drain", 64'(all_out), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("no_avg_after_rst", 64'({o_avg_vld, o_busy, o_rd_en}), 64'd0);
    end

    // Fresh packet after reset
    start_pulse();
    push_reads();
    send(256, 1'b0);
    wait_done(4);

    check("final_ovf_count", 64'(obs_ovf), 64'(exp_ovf));
    check("final_abort_count", 64'(obs_abort), 64'(exp_abort));
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("avg_q_empty", 64'(avg_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
